ifu_pc_gen: RTL and testbench

//  Fetch-PC generator and instruction holding register of the IFU, directly upstream of the bpu.

---
 rtl/ifu_pc_gen_pkg.sv | 27 ++
 rtl/ifu_pc_gen_npc.sv | 30 +++
 rtl/ifu_pc_gen.sv | 119 +++++++++++
 tb/tb_ifu_pc_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pc_gen_pkg.sv
// Shared widths, reset defaults and encodings for the IFU fetch-PC generator.
// The FSM state and next-PC select encodings live here so the top and the adder agree.
package ifu_pc_gen_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h8000_0000;
  localparam logic [INSTR_W-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [ADDR_W-1:0]  ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT      = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_JALR_WAIT = 3'd4,
    ST_DRAIN     = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BPU = 2'd1,
    NPC_FIX = 2'd2
  } npc_sel_e;

endpackage

// File: rtl/ifu_pc_gen_npc.sv
// Next-PC mux: sequential pc+4, bpu target op1+op2, or EXU redirect target.
// Every result is word aligned; carries out of bit 31 are dropped.
module ifu_pc_gen_npc
  import ifu_pc_gen_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] op1_i,
  input  logic [ADDR_W-1:0] op2_i,
  input  logic [ADDR_W-1:0] fix_pc_i,
  input  logic [1:0]        sel_i,
  output logic [ADDR_W-1:0] npc_o
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] bpu_pc;

  assign seq_pc = pc_i + ADDR_W'(4);
  assign bpu_pc = (op1_i + op2_i) & ALIGN_MASK;

  always_comb begin
    // NOTE: output gets a default before the case so no path leaves it unassigned (no latch).
    npc_o = seq_pc;
    case (npc_sel_e'(sel_i))
      NPC_BPU: npc_o = bpu_pc;
      NPC_FIX: npc_o = fix_pc_i & ALIGN_MASK;
      default: npc_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/ifu_pc_gen.sv
// IFU fetch-PC generator: one outstanding fetch at a time, returned word held in IR
// and offered to decode (and the bpu) until accepted or flushed by an EXU redirect.
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prefail,
  input  logic [ADDR_W-1:0]  fix_pc,
  input  logic               pre_pc_vaild,
  input  logic [ADDR_W-1:0]  jump_need_op1,
  input  logic [ADDR_W-1:0]  jump_need_op2,
  input  logic               jalr_need_rs1,
  output logic               ifetch_req_vaild,
  output logic [ADDR_W-1:0]  ifetch_req_addr,
  input  logic               ifetch_req_ready,
  input  logic               ifetch_rsp_vaild,
  input  logic [INSTR_W-1:0] ifetch_rsp_inst,
  output logic               out_inst_vaild,
  output logic [INSTR_W-1:0] out_inst,
  output logic [ADDR_W-1:0]  out_inst_pc,
  output logic               out_pre_taken,
  input  logic               out_inst_ready
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  npc_sel_e           npc_sel;
  logic [ADDR_W-1:0]  npc;
  logic               redirect;

  // BOOT ignores redirects so the first fetch always comes from RESET_PC.
  assign redirect = prefail && (state_q != ST_BOOT);
  assign npc_sel  = redirect     ? NPC_FIX :
                    pre_pc_vaild ? NPC_BPU : NPC_SEQ;

  ifu_pc_gen_npc u_npc (
    .pc_i     (pc_q),
    .op1_i    (jump_need_op1),
    .op2_i    (jump_need_op2),
    .fix_pc_i (fix_pc),
    .sel_i    (npc_sel),
    .npc_o    (npc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;

    unique case (state_q)
      ST_BOOT:  state_d = ST_REQ;
      ST_REQ:   if (ifetch_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ifetch_rsp_vaild) begin
          ir_d    = ifetch_rsp_inst;
          ir_pc_d = pc_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_inst_ready) begin
          if (jalr_need_rs1) begin
            state_d = ST_JALR_WAIT;
          end else begin
            pc_d    = npc;
            state_d = ST_REQ;
          end
        end
      end
      ST_JALR_WAIT: state_d = ST_JALR_WAIT;
      ST_DRAIN:     if (ifetch_rsp_vaild) state_d = ST_REQ;
      default:      state_d = ST_BOOT;
    endcase

    // Any request still in flight (or being accepted right now) must drain before the
    // redirected fetch goes out, so there is never more than one outstanding request.
    if (redirect) begin
      pc_d    = npc;
      ir_d    = ir_q;
      ir_pc_d = ir_pc_q;
      if (((state_q == ST_WAIT || state_q == ST_DRAIN) && !ifetch_rsp_vaild) ||
          (state_q == ST_REQ && ifetch_req_ready)) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled here) and all state uses non-blocking assignments.
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC & ALIGN_MASK;
      ir_q    <= NOP_INST;
      ir_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  assign ifetch_req_vaild = (state_q == ST_REQ);
  assign ifetch_req_addr  = pc_q;
  assign out_inst_vaild   = (state_q == ST_ISSUE);
  assign out_inst         = ir_q;
  assign out_inst_pc      = ir_pc_q;
  assign out_pre_taken    = pre_pc_vaild && out_inst_vaild;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Randomized bench for ifu_pc_gen: a transaction-level model predicts every cycle's
// fetch request and IR presentation; a separate monitor compares them against the DUT.
module tb_ifu_pc_gen;

  localparam logic [31:0] T_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prefail = 1'b0;
  logic [31:0] fix_pc = '0;
  logic        pre_pc_vaild = 1'b0;
  logic [31:0] jump_need_op1 = '0;
  logic [31:0] jump_need_op2 = '0;
  logic        jalr_need_rs1 = 1'b0;
  logic        ifetch_req_vaild;
  logic [31:0] ifetch_req_addr;
  logic        ifetch_req_ready = 1'b0;
  logic        ifetch_rsp_vaild = 1'b0;
  logic [31:0] ifetch_rsp_inst = '0;
  logic        out_inst_vaild;
  logic [31:0] out_inst;
  logic [31:0] out_inst_pc;
  logic        out_pre_taken;
  logic        out_inst_ready = 1'b0;

  always #5 clk = ~clk;

  ifu_pc_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .prefail          (prefail),
    .fix_pc           (fix_pc),
    .pre_pc_vaild     (pre_pc_vaild),
    .jump_need_op1    (jump_need_op1),
    .jump_need_op2    (jump_need_op2),
    .jalr_need_rs1    (jalr_need_rs1),
    .ifetch_req_vaild (ifetch_req_vaild),
    .ifetch_req_addr  (ifetch_req_addr),
    .ifetch_req_ready (ifetch_req_ready),
    .ifetch_rsp_vaild (ifetch_rsp_vaild),
    .ifetch_rsp_inst  (ifetch_rsp_inst),
    .out_inst_vaild   (out_inst_vaild),
    .out_inst         (out_inst),
    .out_inst_pc      (out_inst_pc),
    .out_pre_taken    (out_pre_taken),
    .out_inst_ready   (out_inst_ready)
  );

  typedef struct {
    logic        req_v;
    logic [31:0] req_addr;
    logic        inst_v;
    logic        chk_ir;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        pre_taken;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Stimulus knobs (per mille unless noted).
  int p_rst = 0, p_prefail = 0, p_pre = 0, p_jalr = 0, p_ordy = 1000;
  int p_rdy = 100;  // percent
  int lat_max = 1;
  bit fixed_ops = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // Instruction memory: accepts one request at a time, answers after 1..lat_max cycles.
  initial begin : responder
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] raddr = '0;
    forever begin
      @(posedge clk); #1;
      if (busy && cnt == 0) begin
        ifetch_rsp_vaild = 1'b1;
        ifetch_rsp_inst  = mem_word(raddr);
      end else begin
        ifetch_rsp_vaild = 1'b0;
        ifetch_rsp_inst  = $urandom;
        if (busy) cnt--;
      end
      ifetch_req_ready = !busy && ($urandom_range(99) < p_rdy);
      @(negedge clk);
      if (ifetch_rsp_vaild) busy = 1'b0;
      if (ifetch_req_vaild && ifetch_req_ready) begin
        busy  = 1'b1;
        raddr = ifetch_req_addr;
        cnt   = $urandom_range(lat_max - 1, 0);
      end
    end
  end

  // Reference model: fetch-protocol view built only from the inputs the bench applies.
  initial begin : model
    bit          m_boot = 1'b1, m_need_req = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_ir_v = 1'b0;
    bit          acc, rsp, hs;
    logic [31:0] m_pc = T_RESET_PC, m_ir = T_NOP, m_ir_pc = T_RESET_PC;
    exp_t        e;
    forever begin
      @(negedge clk);
      e.req_v     = m_need_req;
      e.req_addr  = m_pc;
      e.inst_v    = m_ir_v;
      e.chk_ir    = m_ir_v || m_boot;
      e.inst      = m_ir;
      e.inst_pc   = m_ir_pc;
      e.pre_taken = m_ir_v && pre_pc_vaild;
      sb_q.push_back(e);

      if (!rst_n) begin
        m_boot = 1'b1; m_need_req = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_ir_v = 1'b0;
        m_pc = T_RESET_PC; m_ir = T_NOP; m_ir_pc = T_RESET_PC;
      end else if (m_boot) begin
        m_boot = 1'b0;
        m_need_req = 1'b1;
      end else begin
        acc = m_need_req && ifetch_req_ready;
        rsp = m_out && ifetch_rsp_vaild;
        hs  = m_ir_v && out_inst_ready;
        if (prefail) begin
          m_pc   = fix_pc & 32'hFFFF_FFFC;
          m_ir_v = 1'b0;
          if (acc || (m_out && !rsp)) begin
            m_out = 1'b1; m_drop = 1'b1; m_need_req = 1'b0;
          end else begin
            m_out = 1'b0; m_need_req = 1'b1;
          end
        end else begin
          if (acc) begin
            m_need_req = 1'b0; m_out = 1'b1; m_drop = 1'b0;
          end
          if (rsp) begin
            m_out = 1'b0;
            if (m_drop) m_need_req = 1'b1;
            else begin
              m_ir_v = 1'b1; m_ir = mem_word(m_pc); m_ir_pc = m_pc;
            end
          end
          if (hs) begin
            m_ir_v = 1'b0;
            if (!jalr_need_rs1) begin
              m_pc = pre_pc_vaild ? ((jump_need_op1 + jump_need_op2) & 32'hFFFF_FFFC)
                                  : (m_pc + 32'd4);
              m_need_req = 1'b1;
            end
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per cycle and compares with what the DUT presents.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty t=%0t actual=0 entries expected=1", $time);
      end else begin
        e = sb_q.pop_front();
        check("req_vaild", 32'(ifetch_req_vaild), 32'(e.req_v));
        if (e.req_v) check("req_addr", ifetch_req_addr, e.req_addr);
        check("inst_vaild", 32'(out_inst_vaild), 32'(e.inst_v));
        if (e.chk_ir) begin
          check("inst", out_inst, e.inst);
          check("inst_pc", out_inst_pc, e.inst_pc);
        end
        check("pre_taken", 32'(out_pre_taken), 32'(e.pre_taken));
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk); #1;
    rst_n          = ($urandom_range(999) >= p_rst);
    prefail        = ($urandom_range(999) < p_prefail);
    fix_pc         = $urandom;
    pre_pc_vaild   = ($urandom_range(999) < p_pre);
    jalr_need_rs1  = ($urandom_range(999) < p_jalr);
    out_inst_ready = ($urandom_range(999) < p_ordy);
    jump_need_op1  = fixed_ops ? 32'h0000_0020 : $urandom;
    jump_need_op2  = fixed_ops ? 32'h8000_0010 : $urandom;
  endtask

  task automatic drive_prefail(input logic [31:0] tgt);
    drive_cycle();
    prefail = 1'b1;
    fix_pc  = tgt;
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);

    // Sequential fetch from reset, memory answers next cycle.
    repeat (20) drive_cycle();

    // Redirect to the top word; the sequential fetch after it wraps to 0.
    drive_prefail(32'hFFFF_FFFC);
    repeat (15) drive_cycle();

    // Predicted-taken jal: target 0x20 + 0x8000_0010.
    fixed_ops = 1'b1;
    p_pre = 1000;
    repeat (12) drive_cycle();
    p_pre = 0;
    fixed_ops = 1'b0;

    // jalr needing rs1 stalls fetch until the EXU redirect.
    p_jalr = 1000;
    repeat (15) drive_cycle();
    p_jalr = 0;
    drive_prefail(32'h8000_0100);
    repeat (10) drive_cycle();

    // Redirect while waiting on a slow response.
    lat_max = 4;
    repeat (3) drive_cycle();
    drive_prefail(32'h8000_0200);
    repeat (15) drive_cycle();

    // Fully randomized traffic with backpressure, redirects and occasional resets.
    p_pre = 250; p_jalr = 100; p_prefail = 40; p_ordy = 600; p_rdy = 60; p_rst = 5;
    repeat (4000) drive_cycle();

    p_rst = 0; p_prefail = 0; p_jalr = 0;
    repeat (5) drive_cycle();

    @(negedge clk); #3;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
